// File: rtl/e203_exu_bjp_rslv_pkg.sv
// Shared widths, FSM encoding and mispredict helper for the BJP commit resolver.
package e203_exu_bjp_rslv_pkg;

  localparam int PC_W_DFLT  = 32;
  localparam int CNT_W_DFLT = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } rslv_state_e;

  function automatic logic is_mispred(input logic bjp, input logic prdt, input logic rslv);
    return bjp & (prdt ^ rslv);
  endfunction

endpackage

// File: rtl/e203_exu_bjp_rslv_if.sv
// Commit-side, CSR, IFU flush and perf-counter signals of the BJP commit resolver.
interface e203_exu_bjp_rslv_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             cmt_i_valid;
  logic             cmt_i_ready;
  logic             cmt_i_bjp;
  logic             cmt_i_mret;
  logic             cmt_i_dret;
  logic             cmt_i_fencei;
  logic             cmt_i_prdt;
  logic             cmt_i_rslv;
  logic             cmt_i_rv32;
  logic [PC_W-1:0]  cmt_i_pc;
  logic [PC_W-1:0]  cmt_i_imm;
  logic [PC_W-1:0]  csr_epc_r;
  logic [PC_W-1:0]  csr_dpc_r;
  logic             flush_req;
  logic             flush_ack;
  logic [PC_W-1:0]  flush_add_op1;
  logic [PC_W-1:0]  flush_add_op2;
  logic             flush_busy;
  logic [CNT_W-1:0] mispred_cnt;
  logic             mispred_clr;

  modport master (
    output cmt_i_valid, cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_fencei,
           cmt_i_prdt, cmt_i_rslv, cmt_i_rv32, cmt_i_pc, cmt_i_imm,
           csr_epc_r, csr_dpc_r, flush_ack, mispred_clr,
    input  cmt_i_ready, flush_req, flush_add_op1, flush_add_op2,
           flush_busy, mispred_cnt
  );

  modport slave (
    input  cmt_i_valid, cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_fencei,
           cmt_i_prdt, cmt_i_rslv, cmt_i_rv32, cmt_i_pc, cmt_i_imm,
           csr_epc_r, csr_dpc_r, flush_ack, mispred_clr,
    output cmt_i_ready, flush_req, flush_add_op1, flush_add_op2,
           flush_busy, mispred_cnt
  );

endinterface

// File: rtl/e203_exu_bjp_rslv_tgt.sv
// Redirect target selection: flush decision and adder operands, dret > mret > fencei > branch.
// Purely combinational.
module e203_exu_bjp_rslv_tgt
  import e203_exu_bjp_rslv_pkg::*;
#(
  parameter int PC_W = PC_W_DFLT
) (
  input  logic            i_bjp,
  input  logic            i_mret,
  input  logic            i_dret,
  input  logic            i_fencei,
  input  logic            i_prdt,
  input  logic            i_rslv,
  input  logic            i_rv32,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_imm,
  input  logic [PC_W-1:0] i_epc,
  input  logic [PC_W-1:0] i_dpc,
  output logic            o_need_flush,
  output logic            o_mispred,
  output logic [PC_W-1:0] o_op1,
  output logic [PC_W-1:0] o_op2
);

  logic [PC_W-1:0] w_ilen;

  assign w_ilen       = i_rv32 ? PC_W'(4) : PC_W'(2);
  assign o_mispred    = is_mispred(i_bjp, i_prdt, i_rslv);
  assign o_need_flush = i_dret | i_mret | i_fencei | o_mispred;

  always_comb begin
    o_op1 = i_pc;
    o_op2 = '0;
    if (i_dret) begin
      o_op1 = i_dpc;
    end else if (i_mret) begin
      o_op1 = i_epc;
    end else if (i_fencei) begin
      o_op2 = w_ilen;
    end else if (o_mispred) begin
      // Resolved taken jumps to pc+imm; resolved not-taken falls through.
      o_op2 = i_rslv ? i_imm : w_ilen;
    end
  end

endmodule

// File: rtl/e203_exu_bjp_rslv.sv
// Commit-stage flush resolver: registers a redirect one cycle after a flushing commit and
// holds it (ready low, commits ignored) until the IFU acks; also counts branch mispredicts.
module e203_exu_bjp_rslv
  import e203_exu_bjp_rslv_pkg::*;
#(
  parameter int PC_W  = PC_W_DFLT,
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  e203_exu_bjp_rslv_if.slave    bus
);

  rslv_state_e      r_state;
  logic [PC_W-1:0]  r_op1;
  logic [PC_W-1:0]  r_op2;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_need_flush;
  logic             w_mispred;
  logic [PC_W-1:0]  w_op1;
  logic [PC_W-1:0]  w_op2;

  e203_exu_bjp_rslv_tgt #(.PC_W(PC_W)) u_tgt (
    .i_bjp        (bus.cmt_i_bjp),
    .i_mret       (bus.cmt_i_mret),
    .i_dret       (bus.cmt_i_dret),
    .i_fencei     (bus.cmt_i_fencei),
    .i_prdt       (bus.cmt_i_prdt),
    .i_rslv       (bus.cmt_i_rslv),
    .i_rv32       (bus.cmt_i_rv32),
    .i_pc         (bus.cmt_i_pc),
    .i_imm        (bus.cmt_i_imm),
    .i_epc        (bus.csr_epc_r),
    .i_dpc        (bus.csr_dpc_r),
    .o_need_flush (w_need_flush),
    .o_mispred    (w_mispred),
    .o_op1        (w_op1),
    .o_op2        (w_op2)
  );

  assign w_accept          = bus.cmt_i_valid & (r_state == ST_IDLE);
  assign bus.cmt_i_ready   = (r_state == ST_IDLE);
  assign bus.flush_req     = (r_state == ST_FLUSH);
  assign bus.flush_busy    = (r_state == ST_FLUSH);
  assign bus.flush_add_op1 = r_op1;
  assign bus.flush_add_op2 = r_op2;
  assign bus.mispred_cnt   = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op1   <= '0;
      r_op2   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_need_flush) begin
            r_state <= ST_FLUSH;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
          end
        end
        ST_FLUSH: begin
          if (bus.flush_ack) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Clear wins over a concurrent increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.mispred_clr) begin
      r_cnt <= '0;
    end else if (w_accept && w_mispred && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_e203_exu_bjp_rslv.sv
// Directed bench for e203_exu_bjp_rslv; the counter is built 8 bits wide so saturation is reachable quickly.
module tb_e203_exu_bjp_rslv;

  localparam int PC_W  = 32;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   ncmp;
  int   nfail;

  e203_exu_bjp_rslv_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  e203_exu_bjp_rslv #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmt();
    bus.cmt_i_valid  = 1'b0;
    bus.cmt_i_bjp    = 1'b0;
    bus.cmt_i_mret   = 1'b0;
    bus.cmt_i_dret   = 1'b0;
    bus.cmt_i_fencei = 1'b0;
    bus.cmt_i_prdt   = 1'b0;
    bus.cmt_i_rslv   = 1'b0;
    bus.cmt_i_rv32   = 1'b1;
    bus.cmt_i_pc     = '0;
    bus.cmt_i_imm    = '0;
  endtask

  task automatic branch(input logic prdt, input logic rslv, input logic rv32,
                        input logic [31:0] pc, input logic [31:0] imm);
    bus.cmt_i_valid = 1'b1;
    bus.cmt_i_bjp   = 1'b1;
    bus.cmt_i_prdt  = prdt;
    bus.cmt_i_rslv  = rslv;
    bus.cmt_i_rv32  = rv32;
    bus.cmt_i_pc    = pc;
    bus.cmt_i_imm   = imm;
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    rst   = 1'b1;
    idle_cmt();
    bus.csr_epc_r   = 32'h0000_2000;
    bus.csr_dpc_r   = 32'h0000_1000;
    bus.flush_ack   = 1'b0;
    bus.mispred_clr = 1'b0;
    #2;
    check("rst_req",   bus.flush_req, 1'b0);
    check("rst_busy",  bus.flush_busy, 1'b0);
    check("rst_op1",   bus.flush_add_op1, 32'h0);
    check("rst_op2",   bus.flush_add_op2, 32'h0);
    check("rst_cnt",   bus.mispred_cnt, 8'h0);
    check("rst_ready", bus.cmt_i_ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    // Taken branch predicted not-taken, IFU acks on the third flush cycle.
    branch(1'b0, 1'b1, 1'b1, 32'h8000_0100, 32'h0000_0040);
    check("t1_ready", bus.cmt_i_ready, 1'b1);
    step();
    idle_cmt();
    check("t1_req",   bus.flush_req, 1'b1);
    check("t1_busy",  bus.flush_busy, 1'b1);
    check("t1_op1",   bus.flush_add_op1, 32'h8000_0100);
    check("t1_op2",   bus.flush_add_op2, 32'h0000_0040);
    check("t1_cnt",   bus.mispred_cnt, 8'd1);
    check("t1_nrdy",  bus.cmt_i_ready, 1'b0);
    step();
    check("t1_req2",  bus.flush_req, 1'b1);
    step();
    check("t1_req3",  bus.flush_req, 1'b1);
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;
    check("t1_drop",  bus.flush_req, 1'b0);
    check("t1_rdy",   bus.cmt_i_ready, 1'b1);

    // Correctly predicted branches back to back.
    for (int i = 0; i < 3; i++) begin
      branch(1'b1, 1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'h20);
      check("t2_ready", bus.cmt_i_ready, 1'b1);
      step();
      check("t2_noreq", bus.flush_req, 1'b0);
    end
    idle_cmt();
    check("t2_cnt", bus.mispred_cnt, 8'd1);

    // Not-taken predicted taken, 16-bit instruction.
    branch(1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0800);
    step();
    check("t3_op1", bus.flush_add_op1, 32'h200);
    check("t3_op2", bus.flush_add_op2, 32'h2);
    check("t3_cnt", bus.mispred_cnt, 8'd2);

    // A mispredicting commit offered during FLUSH is ignored.
    branch(1'b0, 1'b1, 1'b1, 32'h0000_0abc, 32'h0000_0100);
    check("t4_nrdy", bus.cmt_i_ready, 1'b0);
    step();
    check("t4_op1", bus.flush_add_op1, 32'h200);
    check("t4_op2", bus.flush_add_op2, 32'h2);
    check("t4_cnt", bus.mispred_cnt, 8'd2);
    check("t4_req", bus.flush_req, 1'b1);
    idle_cmt();
    bus.flush_ack = 1'b1;
    step();
    check("t4_drop", bus.flush_req, 1'b0);
    // Ack while idle has no effect.
    step();
    bus.flush_ack = 1'b0;
    check("t4_ackidle", bus.flush_req, 1'b0);

    // mret and dret together: dret wins.
    bus.cmt_i_valid = 1'b1;
    bus.cmt_i_mret  = 1'b1;
    bus.cmt_i_dret  = 1'b1;
    step();
    idle_cmt();
    check("t5_op1", bus.flush_add_op1, 32'h1000);
    check("t5_op2", bus.flush_add_op2, 32'h0);
    check("t5_cnt", bus.mispred_cnt, 8'd2);
    check("t5_req", bus.flush_req, 1'b1);

    // Asynchronous reset in the middle of FLUSH.
    #2;
    rst = 1'b1;
    #1;
    check("t6_req",  bus.flush_req, 1'b0);
    check("t6_busy", bus.flush_busy, 1'b0);
    check("t6_rdy",  bus.cmt_i_ready, 1'b1);
    #2;
    rst = 1'b0;
    step();
    check("t6_idle", bus.flush_req, 1'b0);
    check("t6_cnt",  bus.mispred_cnt, 8'd0);

    // mret alone, then fencei (not counted); ack in the first flush cycle.
    bus.cmt_i_valid = 1'b1;
    bus.cmt_i_mret  = 1'b1;
    step();
    idle_cmt();
    check("t7_mret", bus.flush_add_op1, 32'h2000);
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;
    bus.cmt_i_valid  = 1'b1;
    bus.cmt_i_fencei = 1'b1;
    bus.cmt_i_pc     = 32'h0000_0300;
    step();
    idle_cmt();
    check("t7_op1", bus.flush_add_op1, 32'h300);
    check("t7_op2", bus.flush_add_op2, 32'h4);
    check("t7_cnt", bus.mispred_cnt, 8'd0);
    bus.flush_ack = 1'b1;
    step();
    // New commit accepted in the first IDLE cycle; ack there is ignored.
    check("t7_drop", bus.flush_req, 1'b0);
    branch(1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'hFFFF_FFF0);
    check("t7_rdy", bus.cmt_i_ready, 1'b1);
    step();
    bus.flush_ack = 1'b0;
    idle_cmt();
    check("t7_req", bus.flush_req, 1'b1);
    check("t7_op2b", bus.flush_add_op2, 32'hFFFF_FFF0);
    check("t7_cnt1", bus.mispred_cnt, 8'd1);
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;

    // Drive the count to all-ones, then one more, then clear against an increment.
    for (int i = 0; i < 254; i++) begin
      branch(1'b1, 1'b0, 1'b1, 32'h1000, 32'h0);
      step();
      idle_cmt();
      bus.flush_ack = 1'b1;
      step();
      bus.flush_ack = 1'b0;
    end
    check("t8_full", bus.mispred_cnt, 8'hFF);
    branch(1'b1, 1'b0, 1'b1, 32'h1000, 32'h0);
    step();
    idle_cmt();
    check("t8_sat", bus.mispred_cnt, 8'hFF);
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;
    branch(1'b0, 1'b1, 1'b1, 32'h1000, 32'h8);
    bus.mispred_clr = 1'b1;
    step();
    bus.mispred_clr = 1'b0;
    idle_cmt();
    check("t8_clr", bus.mispred_cnt, 8'h0);
    check("t8_req", bus.flush_req, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/e203_exu_bjp_rslv.md
Name: e203_exu_bjp_rslv

Overview:
- Downstream neighbour of the BJP unit: consumes the BJP commit results (cmt_bjp/mret/dret/fencei/prdt/rslv) at the commit stage.
- Decides whether the pipeline must be flushed and computes the redirect target.
- Holds a registered flush request towards the IFU until the IFU acknowledges it.
- Keeps a saturating branch-mispredict counter for performance monitoring.

Parameters:
PC_W, 32, PC/target width (matches E203_PC_SIZE)
CNT_W, 16, mispredict counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
cmt_i_valid  in  1  commit request from BJP path
cmt_i_ready  out  1  commit accepted
cmt_i_bjp  in  1  instruction is branch/jump
cmt_i_mret  in  1  instruction is MRET
cmt_i_dret  in  1  instruction is DRET
cmt_i_fencei  in  1  instruction is FENCE.I
cmt_i_prdt  in  1  predicted taken
cmt_i_rslv  in  1  resolved taken
cmt_i_rv32  in  1  1 = 32-bit instr, 0 = 16-bit
cmt_i_pc  in  PC_W  instruction PC
cmt_i_imm  in  PC_W  sign-extended branch/jump offset
csr_epc_r  in  PC_W  MEPC value
csr_dpc_r  in  PC_W  DPC value
flush_req  out  1  flush/redirect request to IFU
flush_ack  in  1  IFU accepts flush
flush_add_op1  out  PC_W  redirect adder operand 1 (registered)
flush_add_op2  out  PC_W  redirect adder operand 2 (registered)
flush_busy  out  1  flush outstanding; blocks other commit sources
mispred_cnt  out  CNT_W  saturating mispredict count
mispred_clr  in  1  synchronous clear of mispred_cnt

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - flush_req=0, flush_busy=0.
  - flush_add_op1/op2=0.
  - mispred_cnt=0.
- need_flush = cmt_i_dret | cmt_i_mret | cmt_i_fencei | (cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv)).
- Target operands, priority dret > mret > fencei > branch:
  - dret: op1=csr_dpc_r, op2=0.
  - mret: op1=csr_epc_r, op2=0.
  - fencei: op1=pc, op2=(rv32?4:2).
  - Mispredicted taken (rslv=1, prdt=0): op1=pc, op2=imm.
  - Mispredicted not-taken (rslv=0, prdt=1): op1=pc, op2=(rv32?4:2).
  - IFU performs the addition, wrapping modulo 2^PC_W.
- FSM IDLE:
  - cmt_i_ready=1 (combinational).
  - On cmt_i_valid & need_flush: capture op1/op2 and go to FLUSH next cycle.
  - cmt_i_valid & !need_flush: commit completes in the same cycle; state unchanged.
- FSM FLUSH:
  - flush_req=1, flush_busy=1, cmt_i_ready=0; op1/op2 held stable.
  - cmt_i_valid is ignored.
  - On flush_ack: return to IDLE next cycle; the next commit can be accepted in that IDLE cycle.
  - flush_ack in the acceptance cycle (still IDLE) is ignored.
- Latency:
  - Commit to flush_req is exactly 1 cycle.
  - flush_req stays high for ≥1 cycle, until the ack is sampled.
- mispred_cnt:
  - Increments on every accepted bjp commit with prdt != rslv (mret/dret/fencei are not counted).
  - Saturates at all-ones.
  - mispred_clr has priority over increment; when both occur, the result is 0.
- Reset mid-FLUSH: flush_req drops immediately (async) and the pending flush is discarded.
- flush_ack while in IDLE: no effect.

Decomposition:
- Shared package (e203_defines): PC width, CNT width default, FSM state encoding (IDLE=1'b0, FLUSH=1'b1).
- Target-select logic may be split into sub-module e203_exu_bjp_rslv_tgt (pure combinational mux/priority, no state).
- FSM, operand registers and counter stay in the top.

Test Plan:
- Taken branch predicted not-taken:
  - Stimulus: pc=0x8000_0100, imm=0x40, rv32=1, bjp=1, prdt=0, rslv=1, valid=1; IFU acks 3 cycles later.
  - Response: cmt_i_ready=1; next cycle flush_req=1, op1=0x8000_0100, op2=0x40; flush_req holds for 3 cycles, drops the cycle after ack; mispred_cnt=1.
- Correct prediction:
  - Stimulus: bjp=1, prdt=1, rslv=1.
  - Response: flush_req stays 0; mispred_cnt unchanged; back-to-back commits all accepted with ready=1.
- Not-taken, predicted taken, 16-bit:
  - Stimulus: pc=0x200, rv32=0, prdt=1, rslv=0.
  - Response: op1=0x200, op2=2.
- mret and dret together:
  - Stimulus: mret=1 and dret=1, csr_dpc_r=0x1000, csr_epc_r=0x2000.
  - Response: op1=0x1000, op2=0 (dret wins); mispred_cnt unchanged.
- Commit during FLUSH; reset mid-FLUSH:
  - Stimulus: cmt_i_valid=1 while in FLUSH.
  - Response: ready=0 and op1/op2 stable.
  - Stimulus: rst pulse mid-FLUSH.
  - Response: flush_req=0 immediately, then IDLE with ready=1.
- Counter saturation:
  - Stimulus: preload via 0xFFFF mispredicts, then one more mispredict; then mispred_clr concurrent with a mispredict.
  - Response: count stays 0xFFFF, then becomes 0.
